// File: rtl/crt_dma_ctrl_if.sv
// Bus bundle between crt_dma_ctrl and its environment: CPU register port,
// CRT request/acknowledge, bus hold handshake and memory read port.
interface crt_dma_ctrl_if;
  logic [1:0]  iaddr;
  logic [7:0]  idata;
  logic [7:0]  odata;
  logic        iwe_n;
  logic        ird_n;
  logic        drq;
  logic        dack;
  logic [7:0]  ochar;
  logic        hrq;
  logic        hlda;
  logic [15:0] maddr;
  logic        mrd;
  logic [7:0]  mdata;
  logic        tc;

  modport master (
    input  iaddr, idata, iwe_n, ird_n, drq, hlda, mdata,
    output odata, dack, ochar, hrq, maddr, mrd, tc
  );

  modport slave (
    output iaddr, idata, iwe_n, ird_n, drq, hlda, mdata,
    input  odata, dack, ochar, hrq, maddr, mrd, tc
  );
endinterface

// File: rtl/crt_dma_ctrl.sv
// Single-channel DMA sequencer feeding the CRT character path from memory.
// Optional feature: define CRT_DMA_AUTOLOAD_EN for shadow-register autoload at terminal count.
module crt_dma_ctrl #(
  parameter int unsigned WAIT_CYC = 2
) (
  input  logic           clk,
  input  logic           reset,
  crt_dma_ctrl_if.master bus
);

  typedef enum logic [2:0] {S_IDLE, S_HOLD, S_READ, S_ACK, S_RECOV} state_t;

  state_t      state, state_nxt;
  logic [3:0]  wait_cnt;
  logic        rec_cnt;
  logic [15:0] addr;
  logic [13:0] cnt;
  logic        en, burst, autold;
  logic        ff, tc_flag;
  logic        iwe_q, ird_q;
  logic        wr_stb, stat_clr, last_rd, at_tc, busy;
  logic [15:0] addr_base, addr_wr;
  logic [13:0] cnt_base, cnt_wr;
  logic        load_work;
  logic [7:0]  rd_mux;

`ifdef CRT_DMA_AUTOLOAD_EN
  logic [15:0] sh_addr;
  logic [13:0] sh_cnt;
  // Writes build up in the shadow copy; the working copy follows only while disabled.
  assign addr_base = sh_addr;
  assign cnt_base  = sh_cnt;
  assign load_work = ~en;
`else
  assign addr_base = addr;
  assign cnt_base  = cnt;
  assign load_work = 1'b1;
  assign autold    = 1'b0;
`endif

  assign wr_stb   = bus.iwe_n & ~iwe_q & ~bus.hlda;
  assign stat_clr = bus.ird_n & ~ird_q & (bus.iaddr == 2'd3);
  assign last_rd  = (state == S_READ) && (wait_cnt == 4'(WAIT_CYC - 1));
  assign at_tc    = (cnt == 14'd0);
  assign busy     = (state != S_IDLE);
  assign addr_wr  = ff ? {bus.idata, addr_base[7:0]} : {addr_base[15:8], bus.idata};
  assign cnt_wr   = ff ? {bus.idata[5:0], cnt_base[7:0]} : {cnt_base[13:8], bus.idata};

  // Strobe samplers idle high so leaving reset never looks like a rising edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      iwe_q <= 1'b1;
      ird_q <= 1'b1;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      iwe_q <= bus.iwe_n;
      ird_q <= bus.ird_n;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr    <= '0;
      cnt     <= '0;
      en      <= 1'b0;
      burst   <= 1'b0;
      ff      <= 1'b0;
      tc_flag <= 1'b0;
`ifdef CRT_DMA_AUTOLOAD_EN
      sh_addr <= '0;
      sh_cnt  <= '0;
      autold  <= 1'b0;
`endif
    end else begin
      if (stat_clr) tc_flag <= 1'b0;
      if (wr_stb) begin
        case (bus.iaddr)
          2'd0: begin
`ifdef CRT_DMA_AUTOLOAD_EN
            sh_addr <= addr_wr;
`endif
            if (load_work) addr <= addr_wr;
            ff <= ~ff;
          end
          2'd1: begin
`ifdef CRT_DMA_AUTOLOAD_EN
            sh_cnt <= cnt_wr;
`endif
            if (load_work) cnt <= cnt_wr;
            ff <= ~ff;
          end
          2'd2: begin
            en    <= bus.idata[0];
            burst <= bus.idata[2];
`ifdef CRT_DMA_AUTOLOAD_EN
            autold <= bus.idata[1];
`endif
            ff    <= 1'b0;
          end
          default: ;
        endcase
      end
      // Transfer bookkeeping happens on the ACK->RECOV edge and overrides a same-cycle write.
      if (state == S_ACK) begin
        if (!at_tc) begin
          addr <= addr + 16'd1;
          cnt  <= cnt - 14'd1;
        end else begin
          tc_flag <= 1'b1;
`ifdef CRT_DMA_AUTOLOAD_EN
          if (autold) begin
            addr <= sh_addr;
            cnt  <= sh_cnt;
          end else begin
            en <= 1'b0;
          end
`else
          en <= 1'b0;
`endif
        end
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    case (bus.iaddr)
      2'd0:    rd_mux = ff ? addr[15:8] : addr[7:0];
      2'd1:    rd_mux = ff ? {2'b00, cnt[13:8]} : cnt[7:0];
      2'd2:    rd_mux = {5'b0, burst, autold, en};
      default: rd_mux = {5'b0, ff, busy, tc_flag};
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      wait_cnt  <= '0;
      rec_cnt   <= 1'b0;
      bus.ochar <= '0;
      bus.odata <= '0;
    end else begin
      state     <= state_nxt;
      wait_cnt  <= (state == S_READ && !last_rd) ? wait_cnt + 4'd1 : 4'd0;
      rec_cnt   <= (state == S_RECOV) ? ~rec_cnt : 1'b0;
      if (last_rd) bus.ochar <= bus.mdata;
      bus.odata <= rd_mux;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path infers a latch.
    state_nxt = state;
    bus.hrq   = busy;
    bus.mrd   = (state == S_READ);
    bus.dack  = (state == S_ACK);
    bus.tc    = (state == S_ACK) && at_tc;
    bus.maddr = (state == S_READ) ? addr : 16'h0000;
    case (state)
      S_IDLE:  if (en && bus.drq) state_nxt = S_HOLD;
      S_HOLD: begin
        if (bus.hlda)     state_nxt = S_READ;
        else if (!bus.drq) state_nxt = S_IDLE;
      end
      S_READ:  if (last_rd) state_nxt = S_ACK;
      S_ACK:   state_nxt = S_RECOV;
      S_RECOV: begin
        // Two recovery cycles give the CRT controller time to update drq after dack.
        if (rec_cnt) state_nxt = (en && burst && bus.drq) ? S_READ : S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_crt_dma_ctrl.sv
// Scoreboard bench for crt_dma_ctrl: expected transfers are queued as drq is
// driven and checked by a monitor when dack rises.
module tb_crt_dma_ctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  crt_dma_ctrl_if bus();

  crt_dma_ctrl #(.WAIT_CYC(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [15:0] addr;
    logic        tc;
  } xfer_t;

  int    checks = 0;
  int    errors = 0;
  xfer_t exp_q[$];
  xfer_t exp_e;
  bit    auto_hlda   = 1'b0;
  bit    manual_hlda = 1'b0;

  function automatic logic [7:0] mem_byte(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  assign bus.mdata = mem_byte(bus.maddr);

  // CPU side of the hold handshake: either follows hrq or is forced by a test.
  always @(negedge clk) bus.hlda = auto_hlda ? bus.hrq : manual_hlda;

  logic        dack_q  = 1'b0;
  logic        mrd_q   = 1'b0;
  logic [15:0] maddr_q = '0;
  logic [15:0] rd_addr = '0;

  always @(negedge clk) begin
    if (bus.mrd) begin
      if (mrd_q) begin
        checks++;
        if (bus.maddr !== maddr_q) begin
          errors++;
          $display("FAIL maddr_stable: got %h expected %h", bus.maddr, maddr_q);
        end
      end
      rd_addr = bus.maddr;
    end
    if (bus.dack && dack_q) begin
      checks++;
      errors++;
      $display("FAIL dack_width: dack high for more than one cycle");
    end
    if (bus.dack && !dack_q) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_dack: got dack at maddr %h, expected none", rd_addr);
      end else begin
        exp_e = exp_q.pop_front();
        if (rd_addr !== exp_e.addr || bus.ochar !== mem_byte(exp_e.addr) || bus.tc !== exp_e.tc) begin
          errors++;
          $display("FAIL xfer: got addr %h char %h tc %b expected addr %h char %h tc %b",
                   rd_addr, bus.ochar, bus.tc, exp_e.addr, mem_byte(exp_e.addr), exp_e.tc);
        end
      end
    end
    mrd_q   = bus.mrd;
    maddr_q = bus.maddr;
    dack_q  = bus.dack;
  end

  task automatic cpu_write(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.iaddr = a;
    bus.idata = d;
    bus.iwe_n = 1'b0;
    @(negedge clk);
    bus.iwe_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic cpu_read(input logic [1:0] a, output logic [7:0] d);
    @(negedge clk);
    bus.iaddr = a;
    bus.ird_n = 1'b0;
    @(negedge clk);
    d = bus.odata;
    bus.ird_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic expect_read(input string name, input logic [1:0] a, input logic [7:0] want);
    logic [7:0] got;
    cpu_read(a, got);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  task automatic program_regs(input logic [15:0] a, input logic [15:0] c, input logic [7:0] m);
    cpu_write(2'd2, 8'h00);
    cpu_write(2'd0, a[7:0]);
    cpu_write(2'd0, a[15:8]);
    cpu_write(2'd1, c[7:0]);
    cpu_write(2'd1, c[15:8]);
    cpu_write(2'd2, m);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (bus.hrq && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.hrq !== 1'b0) begin
      errors++;
      $display("FAIL %s: hrq still %b after %0d cycles, expected 0", name, bus.hrq, n);
    end
  endtask

  task automatic do_xfer(input logic [15:0] a, input logic t);
    int n = 0;
    exp_q.push_back('{addr: a, tc: t});
    @(negedge clk);
    bus.drq = 1'b1;
    while (!bus.dack && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.dack !== 1'b1) begin
      errors++;
      $display("FAIL dack_timeout: got no dack for addr %h, expected one", a);
    end
    bus.drq = 1'b0;
    wait_idle("xfer_release");
  endtask

  task automatic test_reset;
    #12;
    checks++;
    if ({bus.odata, bus.dack, bus.ochar, bus.hrq, bus.maddr, bus.mrd, bus.tc} !== 36'h0) begin
      errors++;
      $display("FAIL reset_outputs: got odata %h dack %b ochar %h hrq %b maddr %h mrd %b tc %b expected all 0",
               bus.odata, bus.dack, bus.ochar, bus.hrq, bus.maddr, bus.mrd, bus.tc);
    end
    @(negedge clk);
    reset = 1'b0;
    expect_read("reset_status", 2'd3, 8'h00);
    expect_read("reset_mode", 2'd2, 8'h00);
  endtask

  task automatic test_write_block;
    cpu_write(2'd2, 8'h00);
    manual_hlda = 1'b1;
    @(negedge clk);
    cpu_write(2'd0, 8'hAB);
    manual_hlda = 1'b0;
    @(negedge clk);
    expect_read("blocked_ff", 2'd3, 8'h00);
    expect_read("blocked_addr", 2'd0, 8'h00);
    cpu_write(2'd0, 8'hAB);
    expect_read("write_ff_toggle", 2'd3, 8'h04);
    expect_read("addr_hi_old", 2'd0, 8'h00);
    cpu_write(2'd0, 8'hCD);
    expect_read("write_ff_back", 2'd3, 8'h00);
    expect_read("addr_lo_new", 2'd0, 8'hAB);
    cpu_write(2'd0, 8'h11);
    expect_read("addr_hi_new", 2'd0, 8'hCD);
    cpu_write(2'd2, 8'h00);
  endtask

  task automatic test_basic;
    auto_hlda = 1'b1;
    program_regs(16'h1234, 16'h0002, 8'h01);
    do_xfer(16'h1234, 1'b0);
    do_xfer(16'h1235, 1'b0);
    do_xfer(16'h1236, 1'b1);
    expect_read("basic_enable_off", 2'd2, 8'h00);
    expect_read("basic_tc_flag", 2'd3, 8'h01);
    expect_read("basic_tc_clear", 2'd3, 8'h00);
  endtask

  task automatic test_burst;
    int c = 0;
    int nd = 0;
    int d[3];
    bit hrq_seen = 1'b0;
    bit hrq_drop = 1'b0;
    program_regs(16'h2000, 16'h0002, 8'h05);
    exp_q.push_back('{addr: 16'h2000, tc: 1'b0});
    exp_q.push_back('{addr: 16'h2001, tc: 1'b0});
    exp_q.push_back('{addr: 16'h2002, tc: 1'b1});
    @(negedge clk);
    bus.drq = 1'b1;
    while (nd < 3 && c < 100) begin
      @(negedge clk);
      c++;
      if (bus.hrq) hrq_seen = 1'b1;
      else if (hrq_seen) hrq_drop = 1'b1;
      if (bus.dack) begin
        d[nd] = c;
        nd++;
      end
    end
    checks++;
    if (nd != 3) begin
      errors++;
      $display("FAIL burst_count: got %0d dacks expected 3", nd);
    end else begin
      checks += 2;
      if (d[1] - d[0] != 5) begin
        errors++;
        $display("FAIL burst_gap1: got %0d cycles expected 5", d[1] - d[0]);
      end
      if (d[2] - d[1] != 5) begin
        errors++;
        $display("FAIL burst_gap2: got %0d cycles expected 5", d[2] - d[1]);
      end
    end
    checks++;
    if (hrq_drop) begin
      errors++;
      $display("FAIL burst_hrq: got hrq drop mid-burst expected hrq held");
    end
    bus.drq = 1'b0;
    wait_idle("burst_release");
  endtask

  task automatic test_autoload;
    bit rose = 1'b0;
    program_regs(16'h7000, 16'h0000, 8'h03);
`ifdef CRT_DMA_AUTOLOAD_EN
    do_xfer(16'h7000, 1'b1);
    do_xfer(16'h7000, 1'b1);
    expect_read("autoload_mode", 2'd2, 8'h03);
`else
    do_xfer(16'h7000, 1'b1);
    expect_read("autoload_off_mode", 2'd2, 8'h00);
    @(negedge clk);
    bus.drq = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.hrq) rose = 1'b1;
    end
    bus.drq = 1'b0;
    checks++;
    if (rose) begin
      errors++;
      $display("FAIL autoload_off_hrq: got hrq after tc expected none");
    end
`endif
  endtask

  task automatic test_withdraw;
    bit seen = 1'b0;
    auto_hlda   = 1'b0;
    manual_hlda = 1'b0;
    program_regs(16'h3000, 16'h0005, 8'h01);
    @(negedge clk);
    bus.drq = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.hrq !== 1'b1) begin
      errors++;
      $display("FAIL withdraw_hrq_up: got %b expected 1", bus.hrq);
    end
    bus.drq = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.hrq !== 1'b0) begin
      errors++;
      $display("FAIL withdraw_hrq_down: got %b expected 0", bus.hrq);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.mrd || bus.dack || bus.hrq) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL withdraw_quiet: got bus activity expected none");
    end
  endtask

  task automatic test_reset_mid;
    int n = 0;
    auto_hlda = 1'b1;
    program_regs(16'h4321, 16'h0003, 8'h01);
    @(negedge clk);
    bus.drq = 1'b1;
    while (!bus.mrd && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.mrd !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_reach_read: got mrd %b expected 1", bus.mrd);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({bus.mrd, bus.hrq, bus.dack, bus.maddr} !== 19'h0) begin
      errors++;
      $display("FAIL reset_mid_async: got mrd %b hrq %b dack %b maddr %h expected all 0",
               bus.mrd, bus.hrq, bus.dack, bus.maddr);
    end
    bus.drq = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    expect_read("reset_mid_status", 2'd3, 8'h00);
  endtask

  initial begin
    reset     = 1'b1;
    bus.iaddr = 2'd0;
    bus.idata = 8'h00;
    bus.iwe_n = 1'b1;
    bus.ird_n = 1'b1;
    bus.drq   = 1'b0;
    test_reset();
    test_write_block();
    test_basic();
    test_burst();
    test_autoload();
    test_withdraw();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending transfers expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
